// File: rtl/hdmi_link_sequencer.sv
// Power-up and recovery sequencer for the dual HDMI output paths (sys_clk domain).
// Qualifies PLL lock, releases the clock dividers and HDMI cores, then watches per-channel heartbeats.
module hdmi_link_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DIV_SETTLE_CYCLES  = 64,
  parameter int HB_TIMEOUT         = 4096,
  parameter int BACKOFF_CYCLES     = 256,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pll_lock,
  input  logic       hb_tx,
  input  logic       hb_rx,
  output logic       div_resetn,
  output logic       hdmi_reset_tx,
  output logic       hdmi_reset_rx,
  output logic       ready,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [2:0] retry_cnt,
  output logic [2:0] state
);

  localparam int MAX_A = (LOCK_STABLE_CYCLES > DIV_SETTLE_CYCLES) ? LOCK_STABLE_CYCLES : DIV_SETTLE_CYCLES;
  localparam int MAX_B = (HB_TIMEOUT > BACKOFF_CYCLES) ? HB_TIMEOUT : BACKOFF_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] ZERO         = {CW{1'b0}};
  localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(DIV_SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HB_LAST      = CW'(HB_TIMEOUT - 1);
  localparam logic [CW-1:0] BACKOFF_LAST = CW'(BACKOFF_CYCLES - 1);
  localparam logic [2:0]    MAX_R        = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_LOCK  = 3'd1,
    DIV_SETTLE = 3'd2,
    ARM        = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5,
    LOCKOUT    = 3'd6
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  state_t        cur_state, nxt_state;
  logic [CW-1:0] cnt, cnt_nxt, wd_tx, wd_tx_nxt, wd_rx, wd_rx_nxt;
  logic          seen_tx, seen_tx_nxt, seen_rx, seen_rx_nxt;
  logic [1:0]    cause_nxt, fault_code;
  logic [2:0]    retry_nxt;
  logic          fault_now, state_chg;
  logic [1:0]    lock_sync;
  logic [2:0]    tx_sync, rx_sync;
  logic          lock_s, tx_edge, rx_edge, tx_stall, rx_stall;

  assign lock_s   = lock_sync[1];
  assign tx_edge  = tx_sync[1] ^ tx_sync[2];
  assign rx_edge  = rx_sync[1] ^ rx_sync[2];
  assign tx_stall = (wd_tx == HB_LAST) && !tx_edge;
  assign rx_stall = (wd_rx == HB_LAST) && !rx_edge;
  assign state    = cur_state;

  // Metastability synchronizers for the asynchronous lock and heartbeat inputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= 2'b00;
      tx_sync   <= 3'b000;
      rx_sync   <= 3'b000;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock};
      tx_sync   <= {tx_sync[1:0], hb_tx};
      rx_sync   <= {rx_sync[1:0], hb_rx};
    end
  end

  // Next-state, counter and fault bookkeeping.
  always_comb begin
    nxt_state   = cur_state;
    cnt_nxt     = sat_inc(cnt);
    wd_tx_nxt   = tx_edge ? ZERO : sat_inc(wd_tx);
    wd_rx_nxt   = rx_edge ? ZERO : sat_inc(wd_rx);
    seen_tx_nxt = seen_tx | tx_edge;
    seen_rx_nxt = seen_rx | rx_edge;
    cause_nxt   = fault_cause;
    retry_nxt   = retry_cnt;
    fault_now   = 1'b0;
    fault_code  = 2'b00;
    if (!enable) begin
      nxt_state = IDLE;
      cause_nxt = 2'b00;
      retry_nxt = 3'b000;
    end else begin
      case (cur_state)
        IDLE: begin
          nxt_state = WAIT_LOCK;
          cause_nxt = 2'b00;
          retry_nxt = 3'b000;
        end
        WAIT_LOCK: begin
          if (!lock_s) cnt_nxt = ZERO;
          else if (cnt == LOCK_LAST) nxt_state = DIV_SETTLE;
          else nxt_state = WAIT_LOCK;
        end
        DIV_SETTLE: begin
          if (!lock_s) begin
            fault_now  = 1'b1;
            fault_code = 2'b01;
          end else if (cnt == SETTLE_LAST) nxt_state = ARM;
          else nxt_state = DIV_SETTLE;
        end
        ARM, RUN: begin
          // Lock loss outranks tx stall, which outranks rx stall.
          if (!lock_s) begin
            fault_now  = 1'b1;
            fault_code = 2'b01;
          end else if (tx_stall) begin
            fault_now  = 1'b1;
            fault_code = 2'b10;
          end else if (rx_stall) begin
            fault_now  = 1'b1;
            fault_code = 2'b11;
          end else if ((cur_state == ARM) && seen_tx_nxt && seen_rx_nxt) nxt_state = RUN;
          else nxt_state = cur_state;
        end
        FAULT: begin
          if (cnt == BACKOFF_LAST) nxt_state = (retry_cnt >= MAX_R) ? LOCKOUT : WAIT_LOCK;
          else nxt_state = FAULT;
        end
        LOCKOUT: nxt_state = LOCKOUT;
        default: nxt_state = IDLE;
      endcase
    end
    nxt_state = fault_now ? FAULT : nxt_state;
    cause_nxt = fault_now ? fault_code : cause_nxt;
    retry_nxt = fault_now ? ((retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1) : retry_nxt;
    // Every state entry starts all timers and seen flags afresh.
    state_chg   = (nxt_state != cur_state);
    cnt_nxt     = state_chg ? ZERO : cnt_nxt;
    wd_tx_nxt   = state_chg ? ZERO : wd_tx_nxt;
    wd_rx_nxt   = state_chg ? ZERO : wd_rx_nxt;
    seen_tx_nxt = state_chg ? 1'b0 : seen_tx_nxt;
    seen_rx_nxt = state_chg ? 1'b0 : seen_rx_nxt;
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state     <= IDLE;
      cnt           <= ZERO;
      wd_tx         <= ZERO;
      wd_rx         <= ZERO;
      seen_tx       <= 1'b0;
      seen_rx       <= 1'b0;
      div_resetn    <= 1'b0;
      hdmi_reset_tx <= 1'b1;
      hdmi_reset_rx <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
      fault_cause   <= 2'b00;
      retry_cnt     <= 3'b000;
    end else begin
      cur_state     <= nxt_state;
      cnt           <= cnt_nxt;
      wd_tx         <= wd_tx_nxt;
      wd_rx         <= wd_rx_nxt;
      seen_tx       <= seen_tx_nxt;
      seen_rx       <= seen_rx_nxt;
      div_resetn    <= (nxt_state == DIV_SETTLE) || (nxt_state == ARM) || (nxt_state == RUN);
      hdmi_reset_tx <= !((nxt_state == ARM) || (nxt_state == RUN));
      hdmi_reset_rx <= !((nxt_state == ARM) || (nxt_state == RUN));
      ready         <= (nxt_state == RUN);
      fault         <= (nxt_state == LOCKOUT);
      fault_cause   <= cause_nxt;
      retry_cnt     <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// Directed bench for hdmi_link_sequencer: bring-up, stalls, cause priority, lockout, lock glitch, async reset.
module tb_hdmi_link_sequencer;

  logic       sys_clk, rst_n, enable, pll_lock, hb_tx, hb_rx;
  logic       div_resetn, hdmi_reset_tx, hdmi_reset_rx, ready, fault;
  logic [1:0] fault_cause;
  logic [2:0] retry_cnt, state;

  hdmi_link_sequencer #(
    .LOCK_STABLE_CYCLES(8), .DIV_SETTLE_CYCLES(4), .HB_TIMEOUT(16),
    .BACKOFF_CYCLES(4), .MAX_RETRIES(2)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .pll_lock(pll_lock),
    .hb_tx(hb_tx), .hb_rx(hb_rx), .div_resetn(div_resetn),
    .hdmi_reset_tx(hdmi_reset_tx), .hdmi_reset_rx(hdmi_reset_rx), .ready(ready),
    .fault(fault), .fault_cause(fault_cause), .retry_cnt(retry_cnt), .state(state)
  );

  // Observation vector: {state, div_resetn, rst_tx, rst_rx, ready, fault, cause, retry}
  localparam logic [12:0] M_ALL   = 13'h1FFF;
  localparam logic [12:0] M_STATE = 13'h1C00;
  localparam logic [12:0] M_DIV   = 13'h0200;
  localparam logic [12:0] M_RDY   = 13'h0040;

  typedef struct {
    string       tag;
    logic [12:0] e;
    logic [12:0] m;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_tx_cyc = 0, last_rx_cyc = 0;
  int   tx_div = 0, rx_div = 0;
  logic tx_run = 1'b0, rx_run = 1'b0;
  int   c, m0, m1, n;

  function automatic logic [12:0] pk(input logic [2:0] s, input logic d, input logic tr, input logic rr,
                                     input logic r, input logic f, input logic [1:0] ca, input logic [2:0] rc);
    return {s, d, tr, rr, r, f, ca, rc};
  endfunction

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
    end
  end

  // Heartbeat sources: each toggles every 5 cycles while its run flag is set.
  initial begin
    hb_tx = 1'b0;
    hb_rx = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_run) begin
        if (tx_div == 4) begin hb_tx = ~hb_tx; last_tx_cyc = cyc; tx_div = 0; end
        else tx_div++;
      end
      if (rx_run) begin
        if (rx_div == 4) begin hb_rx = ~hb_rx; last_rx_cyc = cyc; rx_div = 0; end
        else rx_div++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed cyc %0d required < 20000", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push(input string tag, input logic [12:0] e, input logic [12:0] m);
    exp_t x;
    x.tag = tag; x.e = e; x.m = m;
    sb.push_back(x);
  endtask

  task automatic compare();
    exp_t        x;
    logic [12:0] obs;
    x   = sb.pop_front();
    obs = {state, div_resetn, hdmi_reset_tx, hdmi_reset_rx, ready, fault, fault_cause, retry_cnt};
    tests++;
    assert ((obs & x.m) === (x.e & x.m))
    else begin
      fails++;
      $error("FAIL %s: observed %h required %h (cyc %0d)", x.tag, obs & x.m, x.e & x.m, cyc);
    end
  endtask

  task automatic chk(input string tag, input logic [12:0] e, input logic [12:0] m);
    push(tag, e, m);
    compare();
  endtask

  task automatic wait_ready(input int budget, input string tag, input logic [12:0] e);
    push(tag, e, M_ALL);
    n = 0;
    while (!ready && n < budget) begin tick(); n++; end
    compare();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; pll_lock = 1'b0;
    tick(); tick();
    chk("reset_values", pk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);

    // Clean bring-up.
    rst_n = 1'b1; enable = 1'b1;
    tick();
    chk("idle_to_wait_lock", pk(3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);
    tx_run = 1'b1; rx_run = 1'b1;
    wait_cyc(8);
    pll_lock = 1'b1; m0 = cyc;
    push("div_still_low", pk(3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);
    push("div_release",   pk(3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);
    push("settle_hold",   pk(3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);
    push("hdmi_release",  pk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);
    wait_cyc(m0 + 9);  compare();
    wait_cyc(m0 + 10); compare();
    wait_cyc(m0 + 13); compare();
    wait_cyc(m0 + 14); compare();
    wait_ready(40, "run_ready", pk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd0));

    // tx heartbeat stall in RUN.
    repeat (10) tick();
    tx_run = 1'b0;
    c = last_tx_cyc;
    wait_cyc(c + 18);
    chk("tx_before_expiry", pk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd0), M_ALL);
    wait_cyc(c + 19);
    chk("tx_stall_fault", pk(3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 3'd1), M_ALL);
    wait_cyc(c + 22);
    chk("backoff_hold", pk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0), M_STATE);
    wait_cyc(c + 23);
    chk("retry_wait_lock", pk(3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 3'd1), M_ALL);
    tx_run = 1'b1;
    wait_ready(60, "rerun_ready", pk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'd1));

    // rx watchdog expiry coincides with lock loss; second fault then locks out.
    repeat (3) tick();
    rx_run = 1'b0;
    c = last_rx_cyc;
    wait_cyc(c + 16);
    pll_lock = 1'b0;
    wait_cyc(c + 18);
    chk("rx_before_expiry", pk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd0), M_STATE | M_RDY);
    wait_cyc(c + 19);
    chk("lock_beats_rx", pk(3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'd2), M_ALL);
    wait_cyc(c + 23);
    chk("lockout", pk(3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 3'd2), M_ALL);
    repeat (5) tick();
    chk("lockout_sticky", pk(3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 3'd2), M_ALL);

    // enable pulse low clears lockout.
    enable = 1'b0;
    tick();
    chk("disable_idle", pk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);
    enable = 1'b1; rx_run = 1'b1;
    tick();
    chk("restart_wait_lock", pk(3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);

    // Lock glitch: 5 high, 1 low, then high.
    m0 = cyc;
    pll_lock = 1'b1;
    wait_cyc(m0 + 5); pll_lock = 1'b0;
    wait_cyc(m0 + 6); pll_lock = 1'b1; m1 = cyc;
    wait_cyc(m1 + 4);
    chk("glitch_stay_wait", pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0), M_STATE | M_DIV);
    wait_cyc(m1 + 9);
    chk("glitch_div_low", pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0), M_STATE | M_DIV);
    wait_cyc(m1 + 10);
    chk("glitch_div_high", pk(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0), M_STATE | M_DIV);
    wait_ready(40, "glitch_run", pk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd0));

    // Async reset between clock edges in RUN.
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("async_reset", pk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);
    tick();
    rst_n = 1'b1;
    #1;
    chk("release_idle", pk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);
    tick();
    chk("resume_wait_lock", pk(3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0), M_ALL);

    tests++;
    assert (sb.size() == 0)
    else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d pending required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
